// File: rtl/msrv32_regfile_mp.sv
// Multi-port integer register file: combinational read ports with write bypass,
// two write ports, a busy scoreboard and a sequential one-entry-per-cycle clear engine.
module msrv32_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset_in,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr_in,
  output logic [NUM_RD*XLEN-1:0]   rs_data_out,
  output logic [NUM_RD-1:0]        rs_busy_out,
  input  logic                     wr_en_a_in,
  input  logic [ADDR_W-1:0]        wr_addr_a_in,
  input  logic [XLEN-1:0]          wr_data_a_in,
  input  logic                     wr_en_b_in,
  input  logic [ADDR_W-1:0]        wr_addr_b_in,
  input  logic [XLEN-1:0]          wr_data_b_in,
  input  logic                     issue_en_in,
  input  logic [ADDR_W-1:0]        issue_addr_in,
  input  logic                     clear_req_in,
  output logic                     ready_out
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              clr_we;
  logic              wr_a_ok;
  logic              wr_b_ok;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];

  assign ready_out = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    clr_we    = 1'b0;
    wr_a_ok   = 1'b0;
    wr_b_ok   = 1'b0;
    case (state_q)
      CLEAR: begin
        // clear_req_in is deliberately not looked at here: the sweep never restarts.
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clear_req_in) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          busy_d    = '0;
        end else begin
          wr_a_ok = wr_en_a_in && !((ZERO_REG != 0) && (wr_addr_a_in == '0));
          wr_b_ok = wr_en_b_in && !((ZERO_REG != 0) && (wr_addr_b_in == '0));
          if (wr_en_a_in) busy_d[wr_addr_a_in] = 1'b0;
          if (wr_en_b_in) busy_d[wr_addr_b_in] = 1'b0;
          // Issue is applied after the write clears so it wins on a collision.
          if (issue_en_in) busy_d[issue_addr_in] = 1'b1;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Array has no reset; the clear engine sweeps it instead. Port B is written last so it wins.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (wr_a_ok) mem_q[wr_addr_a_in] <= wr_data_a_in;
      if (wr_b_ok) mem_q[wr_addr_b_in] <= wr_data_b_in;
    end
  end

  always_comb begin
    rs_data_out = '0;
    rs_busy_out = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = rs_addr_in[k*ADDR_W +: ADDR_W];
      if (ready_out) begin
        if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
          rs_data_out[k*XLEN +: XLEN] = '0;
        end else if (wr_en_b_in && (wr_addr_b_in == rd_addr[k])) begin
          rs_data_out[k*XLEN +: XLEN] = wr_data_b_in;
        end else if (wr_en_a_in && (wr_addr_a_in == rd_addr[k])) begin
          rs_data_out[k*XLEN +: XLEN] = wr_data_a_in;
        end else begin
          rs_data_out[k*XLEN +: XLEN] = mem_q[rd_addr[k]];
        end
        rs_busy_out[k] = busy_q[rd_addr[k]];
      end
    end
  end

endmodule

// File: tb/tb_msrv32_regfile_mp.sv
// Bench for msrv32_regfile_mp: array/scoreboard reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_msrv32_regfile_mp;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clock;
  logic                     reset_in;
  logic [NUM_RD*ADDR_W-1:0] rs_addr_in;
  logic [NUM_RD*XLEN-1:0]   rs_data_out;
  logic [NUM_RD-1:0]        rs_busy_out;
  logic                     wr_en_a_in;
  logic [ADDR_W-1:0]        wr_addr_a_in;
  logic [XLEN-1:0]          wr_data_a_in;
  logic                     wr_en_b_in;
  logic [ADDR_W-1:0]        wr_addr_b_in;
  logic [XLEN-1:0]          wr_data_b_in;
  logic                     issue_en_in;
  logic [ADDR_W-1:0]        issue_addr_in;
  logic                     clear_req_in;
  logic                     ready_out;

  msrv32_regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clock(clock), .reset_in(reset_in),
    .rs_addr_in(rs_addr_in), .rs_data_out(rs_data_out), .rs_busy_out(rs_busy_out),
    .wr_en_a_in(wr_en_a_in), .wr_addr_a_in(wr_addr_a_in), .wr_data_a_in(wr_data_a_in),
    .wr_en_b_in(wr_en_b_in), .wr_addr_b_in(wr_addr_b_in), .wr_data_b_in(wr_data_b_in),
    .issue_en_in(issue_en_in), .issue_addr_in(issue_addr_in),
    .clear_req_in(clear_req_in), .ready_out(ready_out)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: contents, busy flags and cycles left in a clear sweep
  logic [XLEN-1:0] ref_mem [DEPTH];
  bit              ref_busy [DEPTH];
  int              clear_left = DEPTH;

  always @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_busy[i] = 1'b0; end
    end else if (clear_left > 0) begin
      clear_left = clear_left - 1;
    end else if (clear_req_in) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_busy[i] = 1'b0; end
    end else begin
      if (wr_en_a_in && wr_addr_a_in != 0) ref_mem[wr_addr_a_in] = wr_data_a_in;
      if (wr_en_b_in && wr_addr_b_in != 0) ref_mem[wr_addr_b_in] = wr_data_b_in;
      if (wr_en_a_in) ref_busy[wr_addr_a_in] = 1'b0;
      if (wr_en_b_in) ref_busy[wr_addr_b_in] = 1'b0;
      if (issue_en_in && issue_addr_in != 0) ref_busy[issue_addr_in] = 1'b1;
    end
  end

  // scoreboard: compare every cycle on the falling edge
  logic [XLEN-1:0] exp_q [$];
  always @(negedge clock) begin
    logic            rdy;
    logic [ADDR_W-1:0] a;
    logic [XLEN-1:0] e;
    logic [XLEN-1:0] got;
    rdy = (clear_left == 0);
    check("ready", {31'b0, ready_out}, {31'b0, rdy});
    for (int k = 0; k < NUM_RD; k++) begin
      a = rs_addr_in[k*ADDR_W +: ADDR_W];
      if (!rdy || a == 0)                      e = '0;
      else if (wr_en_b_in && wr_addr_b_in == a) e = wr_data_b_in;
      else if (wr_en_a_in && wr_addr_a_in == a) e = wr_data_a_in;
      else                                     e = ref_mem[a];
      exp_q.push_back(e);
      exp_q.push_back({31'b0, rdy && ref_busy[a]});
    end
    for (int k = 0; k < NUM_RD; k++) begin
      got = rs_data_out[k*XLEN +: XLEN];
      check($sformatf("rd_data%0d", k), got, exp_q.pop_front());
      check($sformatf("rd_busy%0d", k), {31'b0, rs_busy_out[k]}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    wr_en_a_in = 0; wr_addr_a_in = '0; wr_data_a_in = '0;
    wr_en_b_in = 0; wr_addr_b_in = '0; wr_data_b_in = '0;
    issue_en_in = 0; issue_addr_in = '0; clear_req_in = 0;
  endtask

  task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
    rs_addr_in[k*ADDR_W +: ADDR_W] = a;
  endtask

  // Counts falling edges with ready_out low; pulses clear_req_in at count req_at.
  task automatic count_not_ready(input int req_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (ready_out) break;
      cnt++;
      wr_en_a_in   = 0;
      clear_req_in = (cnt == req_at);
    end
    clear_req_in = 0;
  endtask

  initial begin
    int cnt;
    reset_in   = 0;
    rs_addr_in = '0;
    drive_idle();
    tick(); tick(); tick();

    // reset release, with a write attempted during the sweep
    reset_in = 1;
    wr_en_a_in = 1; wr_addr_a_in = 5'd5; wr_data_a_in = 32'hDEAD_BEEF;
    count_not_ready(-1, cnt);
    check("clear_len_reset", cnt, 32);
    tick();
    set_rd(0, 5'd5); set_rd(1, 5'd31);
    @(negedge clock);
    check("addr5_after_clear", rs_data_out[31:0], 32'h0);
    check("addr31_after_clear", rs_data_out[63:32], 32'h0);

    // bypass then array read
    tick();
    wr_en_a_in = 1; wr_addr_a_in = 5'd3; wr_data_a_in = 32'h1234_5678; set_rd(0, 5'd3);
    @(negedge clock);
    check("bypass_a", rs_data_out[31:0], 32'h1234_5678);
    tick();
    drive_idle();
    @(negedge clock);
    check("array_a", rs_data_out[31:0], 32'h1234_5678);

    // A and B to same address
    tick();
    wr_en_a_in = 1; wr_addr_a_in = 5'd7; wr_data_a_in = 32'h1111_1111;
    wr_en_b_in = 1; wr_addr_b_in = 5'd7; wr_data_b_in = 32'h2222_2222; set_rd(0, 5'd7);
    @(negedge clock);
    check("bypass_ab", rs_data_out[31:0], 32'h2222_2222);
    tick();
    drive_idle();
    @(negedge clock);
    check("array_ab", rs_data_out[31:0], 32'h2222_2222);

    // write to zero register
    tick();
    wr_en_a_in = 1; wr_addr_a_in = 5'd0; wr_data_a_in = 32'hFFFF_FFFF; set_rd(0, 5'd0);
    @(negedge clock);
    check("zero_bypass", rs_data_out[31:0], 32'h0);
    tick();
    drive_idle();
    @(negedge clock);
    check("zero_array", rs_data_out[31:0], 32'h0);

    // scoreboard
    tick();
    issue_en_in = 1; issue_addr_in = 5'd9; set_rd(0, 5'd9);
    tick();
    drive_idle();
    @(negedge clock);
    check("busy_set", {31'b0, rs_busy_out[0]}, 32'd1);
    tick();
    wr_en_b_in = 1; wr_addr_b_in = 5'd9; wr_data_b_in = 32'h0000_0099;
    @(negedge clock);
    check("busy_not_bypassed", {31'b0, rs_busy_out[0]}, 32'd1);
    tick();
    drive_idle();
    @(negedge clock);
    check("busy_cleared", {31'b0, rs_busy_out[0]}, 32'd0);
    tick();
    issue_en_in = 1; issue_addr_in = 5'd9;
    wr_en_a_in = 1; wr_addr_a_in = 5'd9; wr_data_a_in = 32'h0000_0AAA;
    tick();
    drive_idle();
    @(negedge clock);
    check("issue_wins", {31'b0, rs_busy_out[0]}, 32'd1);
    tick();
    issue_en_in = 1; issue_addr_in = 5'd0; set_rd(0, 5'd0);
    tick();
    drive_idle();
    @(negedge clock);
    check("busy0_zero", {31'b0, rs_busy_out[0]}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick();
      wr_en_a_in    = ($urandom_range(0, 1) == 1);
      wr_addr_a_in  = ADDR_W'($urandom_range(0, (i % 2) ? 31 : 7));
      wr_data_a_in  = $urandom;
      wr_en_b_in    = ($urandom_range(0, 1) == 1);
      wr_addr_b_in  = ADDR_W'($urandom_range(0, (i % 2) ? 31 : 7));
      wr_data_b_in  = $urandom;
      issue_en_in   = ($urandom_range(0, 2) == 0);
      issue_addr_in = ADDR_W'($urandom_range(0, (i % 2) ? 31 : 7));
      clear_req_in  = ($urandom_range(0, 199) == 0);
      set_rd(0, ADDR_W'($urandom_range(0, 31)));
      set_rd(1, ADDR_W'($urandom_range(0, 7)));
    end
    tick();
    drive_idle();
    count_not_ready(-1, cnt);

    // fill, mark busy, clear with a repeated request mid-sweep
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      wr_en_a_in = 1; wr_addr_a_in = ADDR_W'(i); wr_data_a_in = 32'hA5A5_0000 | XLEN'(i);
    end
    tick();
    drive_idle();
    issue_en_in = 1; issue_addr_in = 5'd12;
    tick();
    drive_idle();
    set_rd(0, 5'd12);
    @(negedge clock);
    check("busy12_before_clear", {31'b0, rs_busy_out[0]}, 32'd1);
    tick();
    clear_req_in = 1;
    tick();
    clear_req_in = 0;
    count_not_ready(10, cnt);
    check("clear_len_req", cnt, 32);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      set_rd(0, ADDR_W'(i)); set_rd(1, ADDR_W'(DEPTH - 1 - i));
      @(negedge clock);
      check($sformatf("cleared_%0d", i), rs_data_out[31:0], 32'h0);
      check($sformatf("cleared_busy_%0d", i), {31'b0, rs_busy_out[0]}, 32'd0);
    end

    // reset during a clear sweep
    tick();
    clear_req_in = 1;
    tick();
    clear_req_in = 0;
    repeat (10) tick();
    reset_in = 0;
    @(negedge clock);
    check("ready_in_reset", {31'b0, ready_out}, 32'd0);
    tick(); tick();
    reset_in = 1;
    count_not_ready(-1, cnt);
    check("clear_len_after_reset", cnt, 32);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
